// File: rtl/bp_pkg.sv
// Shared constants and types for the branch resolution unit.
package bp_pkg;

  localparam int CNT_W  = 2;
  localparam int PERF_W = 32;

  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_e;

endpackage

// File: rtl/branch_resolver_sat_counter.sv
// Saturating up-counter: increments on i_inc and sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;
  logic         w_full;

  assign w_full  = &r_count;
  assign o_count = r_count;

  // Count events, holding at the maximum instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && !w_full) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: IF prediction, ID/EX prediction tracking, EX resolution
// strobes for predictor training/rollback, front-end redirect and flush,
// plus saturating branch / mispredict performance counters.
//
// Handshake note: there is no valid/ready pair here. A branch in EX is
// consumed ("resolved") only in a cycle where PL_stall is low; while the
// stall is high the EX entry holds and every resolution strobe stays 0.
module branch_resolver #(
  parameter int CNT_W  = bp_pkg::CNT_W,
  parameter int PERF_W = bp_pkg::PERF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PL_stall,
  input  logic              is_branch_if,
  input  logic [CNT_W-1:0]  HP_count,
  input  logic [31:0]       pc_ex,
  input  logic [31:0]       target_ex,
  input  logic              taken_ex,
  output logic              pred_taken,
  output logic              corrected_en,
  output logic              corrected_result,
  output logic              rollback_en_id,
  output logic              rollback_en_ex,
  output logic              redirect_en,
  output logic [31:0]       redirect_pc,
  output logic              flush,
  output logic [PERF_W-1:0] branch_cnt,
  output logic [PERF_W-1:0] mispred_cnt,
  output logic              o_dbg_state
);

  import bp_pkg::*;

  state_e r_state;
  state_e w_state_next;

  logic r_br_v_id;
  logic r_pred_id;
  logic r_br_v_ex;
  logic r_pred_ex;

  logic w_res;
  logic w_mis;

  // A branch resolves when it sits in EX and the pipeline advances.
  assign w_res       = r_br_v_ex & ~PL_stall;
  assign w_mis       = w_res & (taken_ex != r_pred_ex);
  assign o_dbg_state = r_state;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and all combinational outputs; RECOVER suppresses the
  // prediction for one cycle while the predictor table write settles.
  always_comb begin
    w_state_next     = r_state;
    pred_taken       = 1'b0;
    corrected_en     = w_res;
    corrected_result = w_res & taken_ex;
    rollback_en_ex   = w_mis;
    rollback_en_id   = w_mis & r_br_v_id;
    redirect_en      = w_mis;
    flush            = w_mis;
    redirect_pc      = 32'd0;
    if (w_res) begin
      redirect_pc = taken_ex ? target_ex : (pc_ex + PC_INC);
    end
    case (r_state)
      RUN: begin
        pred_taken = is_branch_if & HP_count[CNT_W-1];
        if (w_mis) begin
          w_state_next = RECOVER;
        end
      end
      RECOVER: begin
        w_state_next = RUN;
      end
      default: begin
        w_state_next = RUN;
      end
    endcase
  end

  // ID/EX tracking registers; a flush kills both stages over the shift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_br_v_id <= 1'b0;
      r_pred_id <= 1'b0;
      r_br_v_ex <= 1'b0;
      r_pred_ex <= 1'b0;
    end else begin
      if (!PL_stall) begin
        r_br_v_id <= is_branch_if;
        r_pred_id <= pred_taken;
        r_br_v_ex <= r_br_v_id;
        r_pred_ex <= r_pred_id;
      end
      if (flush) begin
        r_br_v_id <= 1'b0;
        r_br_v_ex <= 1'b0;
      end
    end
  end

  sat_counter #(.W(PERF_W)) u_branch_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_res),
    .o_count (branch_cnt)
  );

  sat_counter #(.W(PERF_W)) u_mispred_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_mis),
    .o_count (mispred_cnt)
  );

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed vectors, a behavioural model checked
// every cycle, and hand-computed literal expectations at key points.
// A second instance with 4-bit counters exercises counter saturation.
module tb_branch_resolver;

  logic        clk;
  logic        rst_n;
  logic        PL_stall;
  logic        is_branch_if;
  logic [1:0]  HP_count;
  logic [31:0] pc_ex;
  logic [31:0] target_ex;
  logic        taken_ex;

  logic        pred_taken, corrected_en, corrected_result;
  logic        rollback_en_id, rollback_en_ex, redirect_en, flush;
  logic [31:0] redirect_pc;
  logic [31:0] branch_cnt, mispred_cnt;
  logic        dbg_state;

  logic        s_pred_taken, s_corrected_en, s_corrected_result;
  logic        s_rollback_en_id, s_rollback_en_ex, s_redirect_en, s_flush;
  logic [31:0] s_redirect_pc;
  logic [3:0]  s_branch_cnt, s_mispred_cnt;
  logic        s_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic drv_rst = 1'b0;

  branch_resolver u_dut (
    .clk(clk), .rst_n(rst_n), .PL_stall(PL_stall), .is_branch_if(is_branch_if),
    .HP_count(HP_count), .pc_ex(pc_ex), .target_ex(target_ex), .taken_ex(taken_ex),
    .pred_taken(pred_taken), .corrected_en(corrected_en),
    .corrected_result(corrected_result), .rollback_en_id(rollback_en_id),
    .rollback_en_ex(rollback_en_ex), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .flush(flush), .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt), .o_dbg_state(dbg_state)
  );

  branch_resolver #(.PERF_W(4)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .PL_stall(PL_stall), .is_branch_if(is_branch_if),
    .HP_count(HP_count), .pc_ex(pc_ex), .target_ex(target_ex), .taken_ex(taken_ex),
    .pred_taken(s_pred_taken), .corrected_en(s_corrected_en),
    .corrected_result(s_corrected_result), .rollback_en_id(s_rollback_en_id),
    .rollback_en_ex(s_rollback_en_ex), .redirect_en(s_redirect_en),
    .redirect_pc(s_redirect_pc), .flush(s_flush), .branch_cnt(s_branch_cnt),
    .mispred_cnt(s_mispred_cnt), .o_dbg_state(s_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // In-flight branches are tracked as "the instruction one stage past IF"
  // and "the instruction two stages past IF", each with its prediction.
  bit     m_valid = 0;
  bit     m_young_v, m_young_p, m_old_v, m_old_p;
  bit     m_recover;
  longint m_bcnt, m_mcnt;

  function automatic longint sat_inc(input longint v, input longint maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  function automatic longint sat_view(input longint v, input longint maxv);
    return (v < maxv) ? v : maxv;
  endfunction

  always @(negedge clk) begin
    bit        e_res, e_mis, e_pred;
    logic [31:0] e_rpc;
    e_pred = is_branch_if && HP_count[1] && !m_recover;
    e_res  = m_old_v && !PL_stall;
    e_mis  = e_res && (taken_ex != m_old_p);
    e_rpc  = 32'd0;
    if (e_res) e_rpc = taken_ex ? target_ex : pc_ex + 32'd4;
    if (m_valid) begin
      check("pred_taken",       pred_taken,       e_pred);
      check("corrected_en",     corrected_en,     e_res);
      check("corrected_result", corrected_result, e_res && taken_ex);
      check("rollback_en_ex",   rollback_en_ex,   e_mis);
      check("rollback_en_id",   rollback_en_id,   e_mis && m_young_v);
      check("redirect_en",      redirect_en,      e_mis);
      check("flush",            flush,            e_mis);
      check("redirect_pc",      redirect_pc,      e_rpc);
      check("state",            dbg_state,        m_recover);
      check("branch_cnt",       branch_cnt,       sat_view(m_bcnt, 64'hFFFF_FFFF));
      check("mispred_cnt",      mispred_cnt,      sat_view(m_mcnt, 64'hFFFF_FFFF));
      check("sat_branch_cnt",   s_branch_cnt,     sat_view(m_bcnt, 15));
      check("sat_mispred_cnt",  s_mispred_cnt,    sat_view(m_mcnt, 15));
    end
    if (!rst_n) begin
      m_valid   = 1;
      m_young_v = 0; m_young_p = 0; m_old_v = 0; m_old_p = 0;
      m_recover = 0; m_bcnt = 0; m_mcnt = 0;
    end else if (m_valid) begin
      if (!PL_stall) begin
        m_old_v   = m_young_v; m_old_p   = m_young_p;
        m_young_v = is_branch_if; m_young_p = e_pred;
      end
      if (e_mis) begin
        m_young_v = 0; m_old_v = 0;
      end
      m_recover = e_mis;
      if (e_res) m_bcnt = sat_inc(m_bcnt, 64'hFFFF_FFFF);
      if (e_mis) m_mcnt = sat_inc(m_mcnt, 64'hFFFF_FFFF);
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic br, input logic [1:0] hp, input logic st,
                     input logic tk, input logic [31:0] pc, input logic [31:0] tgt);
    @(posedge clk); #1;
    rst_n = drv_rst; is_branch_if = br; HP_count = hp; PL_stall = st;
    taken_ex = tk; pc_ex = pc; target_ex = tgt;
    @(negedge clk); #1;
  endtask

  task automatic idle(input logic tk);
    cyc(1'b0, 2'b00, 1'b0, tk, 32'h0000_0010, 32'h0000_0200);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; PL_stall = 1'b0; is_branch_if = 1'b0; HP_count = 2'b00;
    pc_ex = 32'd0; target_ex = 32'd0; taken_ex = 1'b0;

    // Reset held for 3 cycles.
    drv_rst = 1'b0;
    repeat (3) idle(1'b0);
    check("rst_pred_taken",  pred_taken,  1'b0);
    check("rst_corrected",   corrected_en, 1'b0);
    check("rst_flush",       flush,       1'b0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_branch_cnt",  branch_cnt,  32'd0);
    check("rst_mispred_cnt", mispred_cnt, 32'd0);
    drv_rst = 1'b1;

    // Correct taken prediction.
    cyc(1'b1, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0);
    check("t1_pred_taken", pred_taken, 1'b1);
    idle(1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b1, 32'h10, 32'h200);
    check("t1_corrected_en",     corrected_en,     1'b1);
    check("t1_corrected_result", corrected_result, 1'b1);
    check("t1_redirect_en",      redirect_en,      1'b0);
    idle(1'b0);
    check("t1_branch_cnt",  branch_cnt,  32'd1);
    check("t1_mispred_cnt", mispred_cnt, 32'd0);

    // Mispredict not-taken -> taken, then RECOVER.
    cyc(1'b1, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0);
    check("t2_pred_taken", pred_taken, 1'b0);
    idle(1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b1, 32'h80, 32'h100);
    check("t2_redirect_pc", redirect_pc,    32'h100);
    check("t2_flush",       flush,          1'b1);
    check("t2_rollback_ex", rollback_en_ex, 1'b1);
    check("t2_rollback_id", rollback_en_id, 1'b0);
    cyc(1'b1, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0);
    check("t2_recover_pred", pred_taken, 1'b0);
    cyc(1'b1, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0);
    check("t2_run_pred", pred_taken, 1'b1);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    check("t2_nt_correct", corrected_en, 1'b1);
    check("t2_nt_redirect", redirect_en, 1'b0);
    // Mispredict in the same cycle as a new IF branch.
    cyc(1'b1, 2'b11, 1'b0, 1'b0, 32'h20, 32'h900);
    check("t2_mis_redirect_pc", redirect_pc, 32'h24);
    check("t2_mis_flush",       flush,       1'b1);
    idle(1'b1);
    idle(1'b1);
    check("t2_flushed_if_never_resolves", corrected_en, 1'b0);
    check("t2_branch_cnt",  branch_cnt,  32'd4);
    check("t2_mispred_cnt", mispred_cnt, 32'd2);

    // Back-to-back branches, older mispredicted with ID holding a branch.
    cyc(1'b1, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 32'h40, 32'h999);
    check("t3_rollback_id", rollback_en_id, 1'b1);
    check("t3_rollback_ex", rollback_en_ex, 1'b1);
    check("t3_redirect_pc", redirect_pc,    32'h44);
    idle(1'b1);
    idle(1'b1);
    check("t3_younger_killed", corrected_en, 1'b0);

    // Stall with a branch in EX.
    cyc(1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 2'b00, 1'b1, 1'b1, 32'h60, 32'h300);
      check("t4_stall_corrected", corrected_en, 1'b0);
      check("t4_stall_flush",     flush,        1'b0);
    end
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 32'h60, 32'h300);
    check("t4_release_corrected", corrected_en,     1'b1);
    check("t4_release_result",    corrected_result, 1'b0);
    idle(1'b1);
    check("t4_once_only",  corrected_en, 1'b0);
    check("t4_branch_cnt", branch_cnt,   32'd6);

    // Reset in the middle of a mispredict.
    cyc(1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(1'b0);
    drv_rst = 1'b0;
    cyc(1'b0, 2'b00, 1'b0, 1'b1, 32'h70, 32'h500);
    check("t5_pre_reset_flush", flush, 1'b1);
    drv_rst = 1'b1;
    cyc(1'b1, 2'b11, 1'b0, 1'b1, 32'h70, 32'h500);
    check("t5_post_corrected", corrected_en, 1'b0);
    check("t5_post_flush",     flush,        1'b0);
    check("t5_post_pred",      pred_taken,   1'b1);
    check("t5_post_bcnt",      branch_cnt,   32'd0);
    check("t5_post_mcnt",      mispred_cnt,  32'd0);
    idle(1'b1);
    idle(1'b1);
    check("t5_resolve", corrected_en, 1'b1);
    idle(1'b0);
    check("t5_branch_cnt", branch_cnt, 32'd1);

    // Counter saturation: 18 mispredicts against 4-bit counters.
    for (int i = 0; i < 18; i++) begin
      cyc(1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
      idle(1'b0);
      cyc(1'b0, 2'b00, 1'b0, 1'b1, 32'h100 + 32'(i * 8), 32'h800);
      idle(1'b0);
    end
    idle(1'b0);
    check("t6_mispred_cnt",     mispred_cnt,   32'd18);
    check("t6_branch_cnt",      branch_cnt,    32'd19);
    check("t6_sat_mispred_cnt", s_mispred_cnt, 4'hF);
    check("t6_sat_branch_cnt",  s_branch_cnt,  4'hF);

    idle(1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
